// File: rtl/uart_alu_ctrl_if.sv
// Purpose: bundles the uart_rx / ALU / uart_tx facing signals of the sequencer.
// Latency: none, wiring only.
// Backpressure: none; rx and tx sides are 1-cycle strobes with no ready signal.
interface uart_alu_ctrl_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_a;
  logic [NB_DATA-1:0] o_data_b;
  logic [NB_OP-1:0]   o_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic [1:0]         o_err;

  // Sequencer side.
  modport master (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_err
  );

  // UART/ALU environment side.
  modport slave (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_err
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Purpose: collects A, B, opcode bytes from uart_rx, latches the ALU result, launches uart_tx.
// Latency: o_tx_start fires 2 cycles after the opcode strobe.
// Backpressure: none; bytes arriving while a result is in flight are dropped and flagged.
module uart_alu_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic            clk,
  input logic            i_rst,
  uart_alu_ctrl_if.master bus
);
  localparam int NB_TMR = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_TMR-1:0] TMR_LAST = NB_TMR'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NB_TMR-1:0]  r_timer, w_timer_nxt;
  logic [NB_DATA-1:0] r_data_a, r_data_b, r_tx_data;
  logic [NB_OP-1:0]   r_op;
  logic [1:0]         r_err;
  logic               w_ld_a, w_ld_b, w_ld_op, w_ld_tx;
  logic               w_timeout, w_overrun, w_waiting;

  // State register; reset drops straight back to IDLE even mid-transfer.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Next state, inter-byte timer and load enables. A byte on the timeout
  // cycle takes priority, so the timeout only fires when no byte arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_ld_tx     = 1'b0;
    w_waiting   = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);
    w_timeout   = w_waiting && !bus.i_rx_done && (r_timer == TMR_LAST);
    w_overrun   = bus.i_rx_done &&
                  ((r_state == S_EXEC) || (r_state == S_SEND) || (r_state == S_WAIT_TX));
    if (w_waiting && !bus.i_rx_done && !w_timeout) begin
      w_timer_nxt = r_timer + NB_TMR'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (bus.i_rx_done) begin
          w_ld_a      = 1'b1;
          w_state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.i_rx_done) begin
          w_ld_b      = 1'b1;
          w_state_nxt = S_WAIT_OP;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_OP: begin
        if (bus.i_rx_done) begin
          w_ld_op     = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_ld_tx     = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (bus.i_tx_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, opcode and result holding registers plus sticky error flags.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      r_data_a  <= '0;
      r_data_b  <= '0;
      r_op      <= '0;
      r_tx_data <= '0;
      r_err     <= '0;
    end else begin
      if (w_ld_a)    r_data_a  <= bus.i_rx_data;
      if (w_ld_b)    r_data_b  <= bus.i_rx_data;
      if (w_ld_op)   r_op      <= bus.i_rx_data[NB_OP-1:0];
      if (w_ld_tx)   r_tx_data <= bus.i_alu_result;
      if (w_timeout) r_err[0]  <= 1'b1;
      if (w_overrun) r_err[1]  <= 1'b1;
    end
  end

  assign bus.o_data_a   = r_data_a;
  assign bus.o_data_b   = r_data_b;
  assign bus.o_op       = r_op;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_start = (r_state == S_SEND);
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_err      = r_err;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Purpose: randomized frame-level check of uart_alu_ctrl against a transaction model.
// Latency: expects o_tx_start 2 cycles after the opcode strobe.
// Backpressure: exercises overrun bytes during a pending transmit.
module tb_uart_alu_ctrl;
  localparam int TO = 100;

  logic clk;
  logic i_rst;

  uart_alu_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  uart_alu_ctrl #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  // External ALU: 0x20 ADD, 0x22 SUB, anything else XOR.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    if (op == 6'h20) return a + b;
    if (op == 6'h22) return a - b;
    return a ^ b;
  endfunction

  assign bus.i_alu_result = alu_f(bus.o_data_a, bus.o_data_b, bus.o_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state.
  logic [7:0] exp_a, exp_b;
  logic [5:0] exp_op;
  logic [1:0] exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rx_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    step();
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
  endtask

  task automatic tx_done_pulse();
    bus.i_tx_done = 1'b1;
    step();
    bus.i_tx_done = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_a"},   bus.o_data_a, exp_a);
    chk({tag, "_b"},   bus.o_data_b, exp_b);
    chk({tag, "_op"},  bus.o_op,     exp_op);
    chk({tag, "_err"}, bus.o_err,    exp_err);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    i_rst = 1'b0;
    #1;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_err = '0;
    chk_regs(tag);
    chk({tag, "_txd"},   bus.o_tx_data,  0);
    chk({tag, "_start"}, bus.o_tx_start, 0);
    chk({tag, "_busy"},  bus.o_busy,     0);
    #2;
    i_rst = 1'b1;
    step();
  endtask

  // One full frame; ovr=1 drops a byte in WAIT_TX, ovr_done=1 makes it
  // coincide with i_tx_done.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int g1, input int g2, input bit ovr, input bit ovr_done);
    int n;
    logic [7:0] res;
    rx_byte(a); exp_a = a; idle(g1);
    rx_byte(b); exp_b = b; idle(g2);
    rx_byte(opb); exp_op = opb[5:0];
    res = alu_f(a, b, opb[5:0]);
    n = 1;
    while (bus.o_tx_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("latency", n, 2);
    chk("tx_data", bus.o_tx_data, res);
    chk("busy_send", bus.o_busy, 1);
    chk_regs("frame");
    step();
    chk("start_once", bus.o_tx_start, 0);
    idle($urandom_range(0, 3));
    if (ovr && ovr_done) begin
      bus.i_rx_data = 8'($urandom);
      bus.i_rx_done = 1'b1;
      bus.i_tx_done = 1'b1;
      step();
      bus.i_rx_done = 1'b0;
      bus.i_tx_done = 1'b0;
      exp_err[1] = 1'b1;
    end else begin
      if (ovr) begin
        rx_byte(8'($urandom));
        exp_err[1] = 1'b1;
        chk("ovr_txd", bus.o_tx_data, res);
        chk("ovr_busy", bus.o_busy, 1);
        idle($urandom_range(0, 3));
      end
      tx_done_pulse();
    end
    chk("done_busy", bus.o_busy, 0);
    chk_regs("post");
  endtask

  // Partial frame abandoned; in_op selects whether B was received first.
  task automatic run_timeout(input logic [7:0] a, input logic [7:0] b, input bit in_op);
    rx_byte(a); exp_a = a;
    if (in_op) begin
      idle($urandom_range(0, 20));
      rx_byte(b); exp_b = b;
    end
    idle(TO - 1);
    chk("to_pre_busy", bus.o_busy, 1);
    idle(1);
    exp_err[0] = 1'b1;
    chk("to_busy", bus.o_busy, 0);
    chk_regs("to");
  endtask

  initial begin
    i_rst = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    exp_a = '0; exp_b = '0; exp_op = '0; exp_err = '0;
    idle(3);
    chk_regs("rst");
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_start", bus.o_tx_start, 0);
    chk("rst_txd", bus.o_tx_data, 0);
    i_rst = 1'b1;
    idle(2);

    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 0);
    run_frame(8'h03, 8'h05, 8'h22, 2, 1, 0, 0);
    chk("sub_result", bus.o_tx_data, 8'hFE);
    run_frame(8'h40, 8'h10, 8'hE2, 0, 0, 0, 0);
    chk("op_mask", bus.o_op, 6'h22);
    run_frame(8'h77, 8'h11, 8'h20, TO - 1, TO - 1, 0, 0);
    chk("edge_no_to", bus.o_err[0], 0);
    run_timeout(8'h11, 8'h00, 0);
    run_frame(8'h09, 8'h01, 8'h20, 3, 3, 0, 0);
    run_frame(8'h01, 8'h02, 8'h22, 0, 0, 1, 0);
    run_frame(8'h21, 8'h12, 8'h20, 0, 0, 0, 0);

    for (int it = 0; it < 24; it++) begin
      int kind;
      logic [7:0] opb;
      kind = $urandom_range(0, 7);
      opb = 8'($urandom);
      case ($urandom_range(0, 2))
        0: opb[5:0] = 6'h20;
        1: opb[5:0] = 6'h22;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        tx_done_pulse();
        chk("idle_txdone", bus.o_busy, 0);
      end
      case (kind)
        5: run_timeout(8'($urandom), 8'($urandom), 0);
        6: run_timeout(8'($urandom), 8'($urandom), 1);
        3: run_frame(8'($urandom), 8'($urandom), opb, $urandom_range(0, TO - 1),
                     $urandom_range(0, TO - 1), 1, 0);
        4: run_frame(8'($urandom), 8'($urandom), opb, $urandom_range(0, 5),
                     $urandom_range(0, 5), 1, 1);
        default: run_frame(8'($urandom), 8'($urandom), opb, $urandom_range(0, 8),
                           $urandom_range(0, 8), 0, 0);
      endcase
    end

    rx_byte(8'h31);
    rx_byte(8'h42);
    chk("pre_rst_op_busy", bus.o_busy, 1);
    async_reset_check("rst_wop");

    rx_byte(8'h31);
    rx_byte(8'h42);
    rx_byte(8'h20);
    idle(2);
    chk("pre_rst_tx_busy", bus.o_busy, 1);
    async_reset_check("rst_wtx");
    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
